piso_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-bit PISO serial shifter between `NUM_REQ` byte requesters. It sits directly in front of the shifter and drives its `load`/`data_i` inputs. It tracks the shifter's frame timing internally so that a new byte is loaded only when the shifter can accept it. Frames are issued back-to-back with no dead cycle whenever requests are pending.

---
 rtl/piso_tx_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/piso_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_piso_tx_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and frame constants for the PISO transmit arbiter and its shifter.
package piso_tx_pkg;

   typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

   localparam int unsigned FRAME_BITS = 8;
   localparam int unsigned BYTE_W     = 8;
   // Counter holds FRAME_BITS..1 during SHIFT.
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               found
);

   always_comb begin
      logic [ID_W-1:0] k;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         k = ID_W'((32'(ptr) + off) % NUM_REQ);
         if (!found && valid[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/piso_tx_arbiter.sv
// Shares one 8-bit PISO shifter between NUM_REQ byte requesters with back-to-back frames.
// Define PISO_TX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module piso_tx_arbiter
   import piso_tx_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      piso_load,
   output logic [BYTE_W-1:0]         piso_data,
   output logic                      busy,
   output logic [ID_W-1:0]           cur_id,
   output logic                      frame_done
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]    cur_id_q, cur_id_d;
   logic [ID_W-1:0]    ptr_q;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_found;
   logic               load_opp;
   logic               grant_en;
   logic [BYTE_W-1:0]  req_bytes [NUM_REQ];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .valid (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (gnt_idx),
      .found (gnt_found)
   );

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
      end
   end

   // Gating with rst_n keeps every output at its reset value while reset is held.
   assign load_opp = rst_n && ((state_q == IDLE) ||
                               ((state_q == SHIFT) && (cnt_q == CNT_W'(1))));
   assign grant_en = load_opp && gnt_found;

`ifdef PISO_TX_ARB_FIXED_PRIO_EN
   assign ptr_q = '0;
`else
   logic [ID_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (grant_en) begin
         ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_id_d   = cur_id_q;
      piso_load  = 1'b0;
      req_ready  = '0;
      piso_data  = '0;
      frame_done = 1'b0;

      if (grant_en) begin
         piso_load = 1'b1;
         req_ready = grant;
         piso_data = req_bytes[gnt_idx];
         cur_id_d  = gnt_idx;
      end

      unique case (state_q)
         IDLE: begin
            if (grant_en) begin
               state_d = START;
               cnt_d   = CNT_W'(FRAME_BITS);
            end
         end
         START: state_d = SHIFT;
         SHIFT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               frame_done = 1'b1;
               if (grant_en) begin
                  state_d = START;
                  cnt_d   = CNT_W'(FRAME_BITS);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cur_id_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_id_q <= cur_id_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign cur_id = cur_id_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Scoreboard bench: directed requests push expected grants; a negedge monitor checks each load.
module tb_piso_tx_arbiter;

   localparam int unsigned N = 4;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N*8-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          piso_load;
   logic [7:0]    piso_data;
   logic          busy;
   logic [1:0]    cur_id;
   logic          frame_done;

   int            total = 0;
   int            bad = 0;
   exp_t          expq[$];
   logic [7:0]    bq[N][$];
   logic [N-1:0]  hs_seen = '0;
   logic          cur_pend = 1'b0;
   logic [1:0]    cur_exp = '0;

   piso_tx_arbiter #(
      .NUM_REQ (N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .piso_load  (piso_load),
      .piso_data  (piso_data),
      .busy       (busy),
      .cur_id     (cur_id),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endfunction

   function automatic void drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (bq[i].size() != 0);
         req_data[i*8 +: 8] = (bq[i].size() != 0) ? bq[i][0] : 8'h00;
      end
   endfunction

   function automatic logic pending();
      logic p = 1'b0;
      for (int i = 0; i < N; i++) if (bq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   // Advance one clock; requesters whose handshake completed move to their next byte.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs_seen[i] && bq[i].size() != 0) void'(bq[i].pop_front());
      end
      drive();
      #1;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((busy || piso_load || pending()) && n < bound) begin
         step();
         n++;
      end
      chk("wait_idle_in_budget", 32'(n < bound), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic push(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = 2'(id);
      e.data = d;
      expq.push_back(e);
   endtask

   // Monitor: every load must match the next expected grant; cur_id follows one cycle later.
   always @(negedge clk) begin
      exp_t e;
      hs_seen = req_valid & req_ready;
      if (cur_pend) begin
         chk("cur_id", 32'(cur_id), 32'(cur_exp));
         cur_pend = 1'b0;
      end
      if (piso_load) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_load: got ready %0b want no load", req_ready);
         end else begin
            e = expq.pop_front();
            chk("grant_onehot", 32'(req_ready), 32'(1) << e.id);
            chk("piso_data", 32'(piso_data), 32'(e.data));
            cur_exp  = e.id;
            cur_pend = 1'b1;
         end
      end else begin
         chk("ready_without_load", 32'(req_ready), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = '0;
      req_data = '0;
      do_reset();

      // Reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_load", 32'(piso_load), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_data", 32'(piso_data), 32'd0);
      chk("rst_cur_id", 32'(cur_id), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);

      // Single request from IDLE: same-cycle load, 10-cycle isolated frame
      bq[0].push_back(8'hA5);
      push(0, 8'hA5);
      drive();
      #1;
      chk("single_load", 32'(piso_load), 32'd1);
      chk("single_ready", 32'(req_ready), 32'b0001);
      for (int c = 1; c <= 10; c++) begin
         step();
         chk("single_busy", 32'(busy), 32'(c <= 9));
         chk("single_frame_done", 32'(frame_done), 32'(c == 9));
      end

      // Back-to-back from requester 2: second load exactly 9 cycles later, busy stays high
      bq[2].push_back(8'h3C);
      bq[2].push_back(8'hC3);
      push(2, 8'h3C);
      push(2, 8'hC3);
      drive();
      #1;
      for (int c = 1; c <= 19; c++) begin
         step();
         chk("b2b_busy", 32'(busy), 32'(c <= 18));
         if (c <= 9) chk("b2b_load", 32'(piso_load), 32'(c == 9));
      end

      // Fairness from a freshly reset pointer: 0,1,2,3,0,1,2,3
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            bq[i].push_back(8'(8'h10 * (i + 1) + r));
         end
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) push(i, 8'(8'h10 * (i + 1) + r));
      end
      drive();
      #1;
      wait_idle(200);

      // Reset mid-frame; pointer must return to 0 so requester 0 beats 3
      bq[1].push_back(8'h55);
      push(1, 8'h55);
      drive();
      #1;
      repeat (5) step();
      rst_n = 1'b0;
      bq[0].push_back(8'h66);
      bq[3].push_back(8'h77);
      push(0, 8'h66);
      push(3, 8'h77);
      drive();
      #1;
      step();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_load", 32'(piso_load), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      chk("midrst_data", 32'(piso_data), 32'd0);
      chk("midrst_cur_id", 32'(cur_id), 32'd0);
      chk("midrst_frame_done", 32'(frame_done), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_load", 32'(piso_load), 32'd1);
      chk("post_rst_ready", 32'(req_ready), 32'b0001);
      wait_idle(100);

      // Late arrival: requester 1 waits for the last bit cycle of requester 0's frame
      bq[0].push_back(8'h81);
      push(0, 8'h81);
      push(1, 8'h92);
      drive();
      #1;
      step();
      step();
      bq[1].push_back(8'h92);
      drive();
      #1;
      for (int c = 2; c <= 9; c++) begin
         chk("late_ready", 32'(req_ready), (c == 9) ? 32'b0010 : 32'd0);
         if (c < 9) step();
      end
      wait_idle(100);

      chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
